// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for decode_stage.
// The slave modport is the decode stage; master is the fetch/execute side.
interface decode_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_instr;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_ra;
    logic [4:0]      out_rb;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_funct3;
    logic [11:0]     out_ctrl;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_ra, out_rb, out_rd,
               out_imm, out_funct3, out_ctrl, out_illegal
    );

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_ra, out_rb, out_rd,
               out_imm, out_funct3, out_ctrl, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: small instruction FIFO whose head entry is decoded combinationally
// into control fields and a sign-extended immediate.
module decode_stage #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned QUEUE_DEPTH   = 2,
    parameter bit          CHECK_ILLEGAL = 1'b1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_flush,
    decode_stage_if.slave  io_bus
);
    localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    logic [XLEN-1:0] r_pc_mem    [QUEUE_DEPTH];
    logic [31:0]     r_instr_mem [QUEUE_DEPTH];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;

    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    assign w_in_ready  = !i_rst && (r_count < CntW'(QUEUE_DEPTH));
    assign w_out_valid = !i_rst && (r_count != '0);
    assign w_push      = io_bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && io_bus.out_ready;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= io_bus.in_pc;
            r_instr_mem[r_wr_ptr] <= io_bus.in_instr;
        end
    end

    // Flush shares the reset path so a same-cycle push is discarded.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PtrW'(QUEUE_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PtrW'(QUEUE_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm32;
    logic [11:0] w_ctrl;
    logic        w_illegal;
    logic        w_known;

    assign w_instr  = r_instr_mem[r_rd_ptr];
    assign w_opcode = w_instr[6:0];
    assign w_funct3 = w_instr[14:12];

    always_comb begin
        logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op;
        is_lui   = (w_opcode == OpLui);
        is_auipc = (w_opcode == OpAuipc);
        is_jal   = (w_opcode == OpJal);
        is_jalr  = (w_opcode == OpJalr);
        is_br    = (w_opcode == OpBranch);
        is_ld    = (w_opcode == OpLoad);
        is_st    = (w_opcode == OpStore);
        is_opi   = (w_opcode == OpImm);
        is_op    = (w_opcode == OpReg);
        w_known  = is_lui || is_auipc || is_jal || is_jalr || is_br || is_ld || is_st ||
                   is_opi || is_op || (w_opcode == OpFence) || (w_opcode == OpSystem);

        w_ctrl = {
            is_auipc || is_jal || is_br,
            !is_op,
            is_ld || is_st,
            is_st,
            is_br,
            is_jal || is_jalr,
            is_jalr,
            is_lui,
            (is_op && w_instr[30]) || ((is_op || is_opi) && w_funct3[1]),
            w_instr[30],
            w_funct3[1],
            w_funct3[0]
        };

        // I-format is the fallback, covering JALR, LOAD, OP-IMM, FENCE and SYSTEM.
        w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
        if (is_lui || is_auipc) begin
            w_imm32 = {w_instr[31:12], 12'b0};
        end else if (is_jal) begin
            w_imm32 = {{12{w_instr[31]}}, w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
        end else if (is_br) begin
            w_imm32 = {{20{w_instr[31]}}, w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
        end else if (is_st) begin
            w_imm32 = {{21{w_instr[31]}}, w_instr[30:25], w_instr[11:7]};
        end else if (is_op) begin
            w_imm32 = '0;
        end

        w_illegal = CHECK_ILLEGAL && ((w_instr[1:0] != 2'b11) || !w_known ||
                    (is_op && (w_instr[31:25] != 7'b0000000) && (w_instr[31:25] != 7'b0100000)));
    end

    // Outputs read as zero whenever nothing is presented, including during reset.
    always_comb begin
        io_bus.in_ready    = w_in_ready;
        io_bus.out_valid   = w_out_valid;
        io_bus.out_pc      = '0;
        io_bus.out_ra      = '0;
        io_bus.out_rb      = '0;
        io_bus.out_rd      = '0;
        io_bus.out_imm     = '0;
        io_bus.out_funct3  = '0;
        io_bus.out_ctrl    = '0;
        io_bus.out_illegal = 1'b0;
        if (w_out_valid) begin
            io_bus.out_pc      = r_pc_mem[r_rd_ptr];
            io_bus.out_ra      = (w_opcode == OpLui) ? 5'd0 : w_instr[19:15];
            io_bus.out_rb      = w_instr[24:20];
            io_bus.out_rd      = w_instr[11:7];
            io_bus.out_imm     = XLEN'($signed(w_imm32));
            io_bus.out_funct3  = w_funct3;
            io_bus.out_ctrl    = w_ctrl;
            io_bus.out_illegal = w_illegal;
        end
    end
endmodule
